// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the execute-stage controller and the
// iterative multiply/divide unit. The controller is the master.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit. Fixed 33-cycle latency from the
// accepted start to done; result is {hi, lo} and changes only on done.
module mul_div_unit (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  // op encoding: bit 1 selects divide, bit 0 selects unsigned.
  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] result_q, result_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        in_signed;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, a_raw;

  assign in_signed = ~bus.op[0];
  assign a_abs     = (in_signed && bus.a[31]) ? -bus.a : bus.a;
  assign b_abs     = (in_signed && bus.b[31]) ? -bus.b : bus.b;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};

  // Divide: the next dividend bit enters the 33-bit partial remainder.
  assign div_shift = {rem_q, acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, b_q});

  // Sign bits are recorded as zero for unsigned ops, so no op check is needed.
  assign prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix   = sign_a_q ? -rem_q : rem_q;
  assign a_raw     = sign_a_q ? -a_q : a_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          a_d      = a_abs;
          b_d      = b_abs;
          sign_a_d = in_signed & bus.a[31];
          sign_b_d = in_signed & bus.b[31];
          cnt_d    = 6'd0;
          acc_d    = {32'd0, (bus.op[1] ? a_abs : b_abs)};
          rem_d    = 32'd0;
          dbz_d    = 1'b0;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (op_q[1]) begin
          acc_d[31:0] = {acc_q[30:0], div_ge};
          rem_d       = div_ge ? 32'(div_shift - {1'b0, b_q}) : div_shift[31:0];
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIN;
      end

      FIN: begin
        if (op_q[1] && (b_q == 32'd0)) begin
          result_d = {a_raw, 32'hFFFF_FFFF};
          dbz_d    = 1'b1;
        end else if (op_q[1]) begin
          result_d = {rem_fix, quo_fix};
        end else begin
          result_d = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-high here, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      rem_q    <= 32'd0;
      result_q <= 64'd0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old values,
      // independent of statement order.
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, randomized
// operations against a plain-arithmetic model, busy/back-to-back and reset.
module tb_mul_div_unit;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] expect_res;
    logic        expect_dbz;
  } vec_t;

  // Reference: 64-bit integer arithmetic; SV '/' and '%' truncate toward zero.
  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] res,
                                output logic dbz);
    longint sa, sb, q, r;
    dbz = 1'b0;
    if (op[1] && b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
      dbz = 1'b1;
    end else begin
      if (op[0]) begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end
      if (op[1]) begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end else begin
        res = sa * sb;
      end
    end
  endfunction

  // Issues one operation and waits (bounded) for done. Operands are scrambled
  // right after the accepting edge since they only need to be stable there.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [63:0] res,
                        output logic dbz, output int lat, output bit held,
                        output bit dbz_cleared);
    logic [63:0] prev;
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.op      = 2'($urandom_range(0, 3));
    bus.a       = $urandom;
    bus.b       = $urandom;
    dbz_cleared = (bus.div_by_zero === 1'b0);
    held        = 1'b1;
    lat         = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) break;
      if (bus.result !== prev) held = 1'b0;
    end
    res = bus.result;
    dbz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: got %b want 0", bus.done);
    end
    tests_run++;
    if (bus.result !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h want 0", bus.result);
    end
    tests_run++;
    if (bus.div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero);
    end
    // Start together with reset must not be accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_vs_start_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_directed();
    vec_t        vecs[10];
    logic [63:0] res;
    logic        dbz;
    int          lat;
    bit          held, dbz_clr;
    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0};
    vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[4] = '{2'd3, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 1'b0};
    vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0};
    vecs[6] = '{2'd3, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, 1'b1};
    vecs[7] = '{2'd1, 32'd3,         32'd4,         64'h0000_0000_0000_000C, 1'b0};
    vecs[8] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, 1'b1};
    vecs[9] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0};
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, dbz, lat, held, dbz_clr);
      tests_run++;
      if (lat !== 33) begin
        tests_failed++;
        $display("FAIL dir%0d latency: got %0d want 33", i, lat);
      end
      tests_run++;
      if (res !== vecs[i].expect_res) begin
        tests_failed++;
        $display("FAIL dir%0d result: got %h want %h", i, res, vecs[i].expect_res);
      end
      tests_run++;
      if (dbz !== vecs[i].expect_dbz) begin
        tests_failed++;
        $display("FAIL dir%0d div_by_zero: got %b want %b", i, dbz, vecs[i].expect_dbz);
      end
      tests_run++;
      if (!held || !dbz_clr) begin
        tests_failed++;
        $display("FAIL dir%0d hold/clear: got held=%0b dbz_cleared=%0b want 1 1",
                 i, held, dbz_clr);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] res, exp_res;
    logic        dbz, exp_dbz;
    int          lat;
    bit          held, dbz_clr;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       a = 32'h8000_0000;
        default: ;
      endcase
      model(op, a, b, exp_res, exp_dbz);
      run_op(op, a, b, res, dbz, lat, held, dbz_clr);
      tests_run++;
      if (lat !== 33 || res !== exp_res || dbz !== exp_dbz || !held) begin
        tests_failed++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got res=%h dbz=%b lat=%0d held=%0b want res=%h dbz=%b lat=33 held=1",
                 i, op, a, b, res, dbz, lat, held, exp_res, exp_dbz);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp1, exp2, res1, res2;
    logic        d;
    int          first_done, second_done, n_done;
    bit          held;
    model(2'd1, 32'hFFFF_FFFF, 32'h1234_5678, exp1, d);
    model(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, exp2, d);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    first_done  = 0;
    second_done = 0;
    n_done      = 0;
    held        = 1'b1;
    res1        = 64'd0;
    res2        = 64'd0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 5 || k == 20) begin
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end else if (k == 34) begin
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = 32'hFFFF_FFFD;
        bus.b     = 32'h0000_0007;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done == 0) begin
          first_done = k;
          res1       = bus.result;
        end else begin
          second_done = k;
          res2        = bus.result;
        end
      end
      if (k > 33 && k < 67 && bus.result !== exp1) held = 1'b0;
    end
    tests_run++;
    if (first_done !== 33) begin
      tests_failed++;
      $display("FAIL b2b_first_done: got edge %0d want 33", first_done);
    end
    tests_run++;
    if (second_done !== 67) begin
      tests_failed++;
      $display("FAIL b2b_second_done: got edge %0d want 67", second_done);
    end
    tests_run++;
    if (n_done !== 2) begin
      tests_failed++;
      $display("FAIL b2b_done_count: got %0d want 2", n_done);
    end
    tests_run++;
    if (res1 !== exp1) begin
      tests_failed++;
      $display("FAIL b2b_result1: got %h want %h", res1, exp1);
    end
    tests_run++;
    if (res2 !== exp2) begin
      tests_failed++;
      $display("FAIL b2b_result2: got %h want %h", res2, exp2);
    end
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL b2b_hold: got changed result want held %h", exp1);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] res;
    logic        dbz;
    int          lat, n_done;
    bit          held, dbz_clr;
    // Leave a non-zero result and div_by_zero set so the reset is visible.
    run_op(2'd3, 32'd55, 32'd0, res, dbz, lat, held, dbz_clr);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd3;
    bus.a     = 32'd1000;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'd0 ||
        bus.div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got busy=%b done=%b result=%h dbz=%b want 0 0 0 0",
               bus.busy, bus.done, bus.result, bus.div_by_zero);
    end
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) n_done++;
    end
    tests_run++;
    if (n_done !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: got %0d dones want 0", n_done);
    end
    run_op(2'd1, 32'd2, 32'd3, res, dbz, lat, held, dbz_clr);
    tests_run++;
    if (res !== 64'd6 || lat !== 33) begin
      tests_failed++;
      $display("FAIL midreset_after: got res=%h lat=%0d want res=6 lat=33", res, lat);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
